// File: rtl/rsdec_pkg.sv
// Shared GF(2^8) definitions for the RS(255,249) decoder: field width, reduction
// polynomial, the alpha powers used by the syndrome cells and a constant multiplier.
package rsdec_pkg;

  localparam int GF_W = 8;
  // Low byte of x^8+x^7+x^2+x+1; the x^8 term is implied by the shift-out bit.
  localparam logic [GF_W-1:0] GF_POLY = 8'h87;

  typedef logic [GF_W-1:0] gf_sym_t;

  localparam gf_sym_t ALPHA_POW [1:6] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  // With c fixed at elaboration this reduces to a pure XOR network.
  function automatic gf_sym_t gf_mul_const(gf_sym_t a, gf_sym_t c);
    gf_sym_t p;
    gf_sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < GF_W; i++) begin
      if (c[i]) p = p ^ x;
      x = {x[GF_W-2:0], 1'b0} ^ (x[GF_W-1] ? GF_POLY : '0);
    end
    return p;
  endfunction

endpackage

// File: rtl/rsdec_syn_cell.sv
// One Horner accumulator: acc <= acc*ALPHA ^ sym, or a restart with sym on ld.
module rsdec_syn_cell
  import rsdec_pkg::*;
#(
  parameter gf_sym_t ALPHA = 8'h02
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ld,
  input  logic       en,
  input  logic [7:0] sym,
  output logic [7:0] acc
);

  gf_sym_t acc_q;
  gf_sym_t acc_d;

  always_comb begin
    acc_d = acc_q;
    if (ld)      acc_d = sym;
    else if (en) acc_d = gf_mul_const(acc_q, ALPHA) ^ sym;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/rsdec_syn.sv
// RS(255,249) syndrome calculator: six Horner cells, symbol framing counter and a
// registered syndrome output stage with valid/ready handshakes on both sides.
module rsdec_syn
  import rsdec_pkg::*;
#(
  parameter int N    = 255,
  parameter int NSYN = 6
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_sym,
  input  logic       in_sop,
  output logic [7:0] syndrome0,
  output logic [7:0] syndrome1,
  output logic [7:0] syndrome2,
  output logic [7:0] syndrome3,
  output logic [7:0] syndrome4,
  output logic [7:0] syndrome5,
  output logic       syn_nz,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       blk_err
);

  if (NSYN != 6) begin : g_nsyn_chk
    $error("rsdec_syn supports only NSYN == 6");
  end
  if (N < 7 || N > 255) begin : g_n_chk
    $error("rsdec_syn requires N in 7..255");
  end

  localparam logic [7:0] LAST = 8'(N - 1);

  logic [7:0] count_q, count_d;
  logic       out_valid_q, out_valid_d;
  logic       syn_nz_q, syn_nz_d;
  logic       blk_err_q, blk_err_d;
  gf_sym_t    syn_q [6];
  gf_sym_t    syn_d [6];
  gf_sym_t    acc_w [6];
  gf_sym_t    fin_w [6];
  logic       take, start, last;

  assign in_ready = ~((count_q == LAST) & out_valid_q & ~out_ready);
  assign take     = in_valid & in_ready;
  assign start    = take & ((count_q == 8'd0) | in_sop);
  assign last     = take & ~start & (count_q == LAST);

  for (genvar gi = 0; gi < 6; gi++) begin : g_cell
    rsdec_syn_cell #(.ALPHA(ALPHA_POW[gi+1])) u_cell (
      .clk  (clk),
      .clrn (clrn),
      .ld   (start),
      .en   (take),
      .sym  (in_sym),
      .acc  (acc_w[gi])
    );
    // Value the cell is about to register; lets the output stage load on the last symbol.
    assign fin_w[gi] = gf_mul_const(acc_w[gi], ALPHA_POW[gi+1]) ^ in_sym;
  end

  always_comb begin
    count_d     = count_q;
    out_valid_d = out_valid_q;
    syn_nz_d    = syn_nz_q;
    blk_err_d   = take & in_sop & (count_q != 8'd0);
    for (int i = 0; i < 6; i++) syn_d[i] = syn_q[i];

    if (start)     count_d = 8'd1;
    else if (last) count_d = 8'd0;
    else if (take) count_d = count_q + 8'd1;

    // last cannot fire while the output is held, so a completed block never overwrites it.
    if (last) begin
      out_valid_d = 1'b1;
      syn_nz_d    = 1'b0;
      for (int i = 0; i < 6; i++) begin
        syn_d[i] = fin_w[i];
        syn_nz_d = syn_nz_d | (|fin_w[i]);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
      syn_nz_q    <= 1'b0;
      blk_err_q   <= 1'b0;
      for (int i = 0; i < 6; i++) syn_q[i] <= '0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      syn_nz_q    <= syn_nz_d;
      blk_err_q   <= blk_err_d;
      for (int i = 0; i < 6; i++) syn_q[i] <= syn_d[i];
    end
  end

  assign syndrome0 = syn_q[0];
  assign syndrome1 = syn_q[1];
  assign syndrome2 = syn_q[2];
  assign syndrome3 = syn_q[3];
  assign syndrome4 = syn_q[4];
  assign syndrome5 = syn_q[5];
  assign syn_nz    = syn_nz_q;
  assign out_valid = out_valid_q;
  assign blk_err   = blk_err_q;

endmodule

// File: tb/tb_rsdec_syn.sv
// Directed bench for rsdec_syn: known single-symbol blocks, output backpressure,
// mid-block restart and asynchronous reset, with a small GF model for random blocks.
module tb_rsdec_syn;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_sym = 8'h00;
  logic       in_sop = 1'b0;
  logic [7:0] syndrome0, syndrome1, syndrome2, syndrome3, syndrome4, syndrome5;
  logic       syn_nz;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       blk_err;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] blk [255];
  logic [47:0] exp_syn;

  localparam logic [47:0] SYN_ONE  = 48'h01_01_01_01_01_01;
  localparam logic [47:0] SYN_DEG1 = 48'h02_04_08_10_20_40;
  localparam logic [47:0] SYN_DEG2 = 48'h04_10_40_87_95_DD;

  rsdec_syn #(.N(255), .NSYN(6)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_sop    (in_sop),
    .syndrome0 (syndrome0),
    .syndrome1 (syndrome1),
    .syndrome2 (syndrome2),
    .syndrome3 (syndrome3),
    .syndrome4 (syndrome4),
    .syndrome5 (syndrome5),
    .syn_nz    (syn_nz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .blk_err   (blk_err)
  );

  always #5 clk = ~clk;

  wire [47:0] syn_all = {syndrome0, syndrome1, syndrome2, syndrome3, syndrome4, syndrome5};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h0187 << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [47:0] ref_syn();
    logic [47:0] r;
    logic [7:0]  a, s;
    r = '0;
    a = 8'h01;
    for (int j = 0; j < 6; j++) begin
      a = ref_mul(a, 8'h02);
      s = 8'h00;
      for (int i = 0; i < 255; i++) s = ref_mul(s, a) ^ blk[i];
      r[47-8*j -: 8] = s;
    end
    return r;
  endfunction

  task automatic fill_zero();
    for (int i = 0; i < 255; i++) blk[i] = 8'h00;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 255; i++) blk[i] = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] s, input logic sop);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_sym   = s;
    in_sop   = sop;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input logic sop_first, input int maxgap);
    for (int i = from; i <= to; i++) begin
      if (maxgap > 0) begin
        repeat ($urandom_range(0, maxgap)) begin
          @(posedge clk);
          #1;
        end
      end
      send(blk[i], (i == from) ? sop_first : 1'b0);
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_syn", 64'(syn_all), 64'd0);
    check("rst_syn_nz", 64'(syn_nz), 64'd0);
    check("rst_blk_err", 64'(blk_err), 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // All-zero block, no in_sop: counter framing
    fill_zero();
    send_range(0, 253, 1'b0, 0);
    check("zero_pre_valid", 64'(out_valid), 64'd0);
    send(blk[254], 1'b0);
    check("zero_valid", 64'(out_valid), 64'd1);
    check("zero_syn", 64'(syn_all), 64'd0);
    check("zero_nz", 64'(syn_nz), 64'd0);
    $display("block zero: syn=%012h nz=%0b", syn_all, syn_nz);
    @(posedge clk);
    #1;
    check("zero_valid_clr", 64'(out_valid), 64'd0);

    // Last symbol 0x01: every syndrome is 1
    fill_zero();
    blk[254] = 8'h01;
    send_range(0, 254, 1'b1, 0);
    check("one_syn", 64'(syn_all), 64'(SYN_ONE));
    check("one_nz", 64'(syn_nz), 64'd1);
    $display("block one: syn=%012h nz=%0b", syn_all, syn_nz);
    @(posedge clk);
    #1;

    // Degree-1 coefficient 0x01: syndromes are alpha^(j+1)
    fill_zero();
    blk[253] = 8'h01;
    send_range(0, 254, 1'b1, 0);
    check("deg1_syn", 64'(syn_all), 64'(SYN_DEG1));
    $display("block deg1: syn=%012h", syn_all);
    @(posedge clk);
    #1;

    // Backpressure: hold output, stream a second (degree-2) block
    out_ready = 1'b0;
    fill_zero();
    blk[254] = 8'h01;
    send_range(0, 254, 1'b1, 0);
    check("bp_a_valid", 64'(out_valid), 64'd1);
    check("bp_a_syn", 64'(syn_all), 64'(SYN_ONE));
    fill_zero();
    blk[252] = 8'h01;
    send_range(0, 253, 1'b1, 0);
    check("bp_ready_low", 64'(in_ready), 64'd0);
    check("bp_a_hold", 64'(syn_all), 64'(SYN_ONE));
    in_valid = 1'b1;
    in_sym   = blk[254];
    repeat (3) @(negedge clk);
    check("bp_ready_stall", 64'(in_ready), 64'd0);
    check("bp_a_hold2", 64'(syn_all), 64'(SYN_ONE));
    check("bp_a_valid_hold", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #1;
    check("bp_ready_rise", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_b_valid", 64'(out_valid), 64'd1);
    check("bp_b_syn", 64'(syn_all), 64'(SYN_DEG2));
    $display("block bp: syn=%012h", syn_all);
    @(posedge clk);
    #1;
    check("bp_valid_clr", 64'(out_valid), 64'd0);

    // Mid-block in_sop at symbol 100
    fill_rand();
    send_range(0, 99, 1'b1, 0);
    fill_zero();
    blk[252] = 8'h01;
    send(blk[0], 1'b1);
    check("sop_blk_err", 64'(blk_err), 64'd1);
    check("sop_no_out", 64'(out_valid), 64'd0);
    send(blk[1], 1'b0);
    check("sop_blk_err_clr", 64'(blk_err), 64'd0);
    send_range(2, 253, 1'b0, 0);
    check("sop_no_out2", 64'(out_valid), 64'd0);
    send(blk[254], 1'b0);
    check("sop_valid", 64'(out_valid), 64'd1);
    check("sop_syn", 64'(syn_all), 64'(SYN_DEG2));
    $display("block sop: syn=%012h", syn_all);
    out_ready = 1'b0;

    // Asynchronous reset mid-block with gaps, then a random block vs model
    fill_rand();
    send_range(0, 49, 1'b1, 3);
    #3;
    clrn = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_syn", 64'(syn_all), 64'd0);
    check("arst_nz", 64'(syn_nz), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    clrn      = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    fill_rand();
    exp_syn = ref_syn();
    send_range(0, 254, 1'b1, 3);
    check("rand_valid", 64'(out_valid), 64'd1);
    check("rand_syn", 64'(syn_all), 64'(exp_syn));
    check("rand_nz", 64'(syn_nz), 64'(exp_syn != 48'd0));
    $display("block rand: syn=%012h", syn_all);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rsdec_syn.md
Name: rsdec_syn

Overview:
- Syndrome calculator for the RS(255,249) decoder over GF(2^8); the code corrects t=3 errors.
- Sits directly upstream of the Berlekamp stage.
- Accepts one received symbol per cycle through a valid/ready handshake and evaluates the received polynomial at alpha^1..alpha^6 using Horner's rule.
- Presents six registered syndromes, plus a nonzero flag, through an output valid/ready handshake. Berlekamp loads them when it is enabled.

Parameters:
- N, 255: code length in symbols, range 7..255.
- NSYN, 6: number of syndromes (2t). Fixed at 6 in this revision; the RTL asserts if it differs.

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- in_valid  in  1  in_sym is valid this cycle
- in_ready  out  1  block can accept a symbol
- in_sym  in  8  received symbol; highest-degree coefficient arrives first
- in_sop  in  1  first symbol of a block; qualified by in_valid&in_ready
- syndrome0..syndrome5  out  8 each  S_j = r(alpha^(j+1))
- syn_nz  out  1  OR of all syndromes being nonzero (the block has errors)
- out_valid  out  1  syndromes hold a completed block
- out_ready  in  1  downstream has taken or will take the syndromes
- blk_err  out  1  one-cycle pulse: in_sop seen mid-block, partial block discarded

Behaviour:
- Field and clocking:
  - GF(2^8), primitive polynomial x^8+x^7+x^2+x+1 (0x187), alpha = 0x02. This matches the decoder's existing multiplier.
  - One clock; reset is asynchronous and active-low (clrn), acting on the falling edge.
- Reset values:
  - All accumulators, output syndromes, syn_nz, out_valid, blk_err and the symbol count are 0.
  - in_ready is 1.
- Accept condition: acc = in_valid & in_ready.
- On acc with count==0, or with in_sop:
  - acc_j <= in_sym for every j (Horner restart).
  - count <= 1.
- On acc otherwise:
  - acc_j <= (acc_j * alpha^(j+1)) ^ in_sym, using constant multipliers only.
  - count <= count+1.
- Block end:
  - The block ends on acc with count == N-1.
  - Next cycle: syndrome_j <= final acc_j, syn_nz <= |final values, out_valid <= 1, count <= 0.
  - Latency from the last symbol to out_valid is 1 cycle.
- Output hold:
  - syndromes and out_valid hold while out_valid & ~out_ready.
  - The cycle out_valid & out_ready is seen, out_valid clears, unless a new block completes in that same cycle; then the new values load and out_valid stays 1.
- Backpressure:
  - in_ready = ~(count == N-1 & out_valid & ~out_ready).
  - Only the last symbol of a block stalls; the accumulators keep working for the next block while the output is held.
- Mid-block in_sop (count != 0):
  - Pulse blk_err for 1 cycle.
  - Restart the accumulators with in_sym; the partial block produces no output.
- in_sop on count==0 is normal; a missing in_sop on the first symbol is accepted (the counter defines framing).
- No state changes when in_valid=0. Gaps between symbols are allowed anywhere in a block.
- Reset mid-block: everything returns to its reset value immediately and the partial block is lost.

Decomposition:
- Package rsdec_pkg holds:
  - GF_W=8, GF_POLY=8'h87 (low byte of 0x187)
  - ALPHA_POW[1..6] = 02,04,08,10,20,40
  - gf_sym_t typedef
  - a constant function gf_mul_const.
- Sub-module rsdec_syn_cell: one Horner accumulator with a hard-wired alpha power (ports clk, clrn, ld, en, sym, acc), instantiated 6 times.
- The top level holds the counter, the handshake logic and the output registers.

Test Plan:
- All-zero block, 255 symbols, out_ready=1 -> out_valid 1 cycle after the last symbol; syndromes all 00; syn_nz=0.
- Zero block with last symbol 0x01 -> all six syndromes 01; syn_nz=1.
- Zero block with symbol 253 (degree 1) = 0x01 -> syndromes 02,04,08,10,20,40.
- out_ready held 0 while a second block streams -> in_ready drops only on its last symbol; the first syndromes stay stable; raise out_ready -> the second result appears on the next cycle, with no symbol lost.
- in_sop asserted at symbol 100 of a block -> blk_err pulses once; the following 255 symbols give the correct syndromes; no output for the truncated block.
- clrn pulsed low mid-block with random in_valid gaps -> outputs take their reset values asynchronously; the next full block's syndromes match the reference model.
